multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle MIPS core. It sequences IF/ID/EX/MEM/WB over the shared ALU, PC, IR, register file and memory port.
//  It drives aluop/cmpflag into alu_control and all mux/write enables. It stalls on a single-port memory handshake.

---
 rtl/multicycle_ctrl_pkg.sv | 45 ++++
 rtl/multicycle_ctrl_if.sv | 18 +
 rtl/ctrl_decode.sv | 25 ++
 rtl/multicycle_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared opcode, state and mux-select encodings for the multicycle controller.
// Imported by the decoder and the FSM top.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_CMP   = 6'b111000;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_ADDI  = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef struct packed {
        logic is_r;
        logic is_mem;
        logic is_ld;
        logic is_br;
        logic is_j;
        logic is_imm;
        logic is_ill;
    } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Single-port memory handshake between the controller and the memory.
// The controller is the master; memory answers with mem_ready.
interface multicycle_ctrl_if;
    logic mem_re;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_re, mem_we, iord,
        input  mem_ready
    );

    modport slave (
        input  mem_re, mem_we, iord,
        output mem_ready
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode to instruction-class decode for the multicycle controller.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output iclass_t    cls
);

    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_RTYPE: cls.is_r = 1'b1;
            OP_LW: begin
                cls.is_mem = 1'b1;
                cls.is_ld  = 1'b1;
            end
            OP_SW:   cls.is_mem = 1'b1;
            OP_BEQ:  cls.is_br  = 1'b1;
            OP_J:    cls.is_j   = 1'b1;
            OP_ADDI: cls.is_imm = 1'b1;
            default: cls.is_ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main IF/ID/EX/MEM/WB control FSM with memory-stall timeout.
// Define CTRL_PERF_EN to add perf_cycles/perf_retired counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 0
`ifdef CTRL_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    multicycle_ctrl_if.master     bus,
    output logic                  pc_we,
    output logic [1:0]            pc_src,
    output logic                  ir_we,
    output logic                  reg_we,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            aluop,
    output logic                  cmpflag,
    output logic                  ill_instr,
    output logic                  bus_err
`ifdef CTRL_PERF_EN
    , output logic [PERF_W-1:0]   perf_cycles
    , output logic [PERF_W-1:0]   perf_retired
`endif
);

    localparam bit         WAIT_EN  = (MEM_WAIT_MAX != 0);
    localparam logic [7:0] WAIT_LIM = 8'(MEM_WAIT_MAX);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    iclass_t    cls;
    logic       waiting;
    logic       timeout;

    ctrl_decode u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_we       = 1'b0;
        pc_src      = PC_ALU;
        ir_we       = 1'b0;
        bus.iord    = 1'b0;
        bus.mem_re  = 1'b0;
        bus.mem_we  = 1'b0;
        reg_we      = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RT;
        aluop       = ALUOP_ADD;
        cmpflag     = 1'b0;
        ill_instr   = 1'b0;
        bus_err     = 1'b0;

        waiting = (state_q == S_IF || state_q == S_MEM) && !bus.mem_ready;
        timeout = WAIT_EN && waiting && (wait_q == WAIT_LIM) && !rst;

        unique case (state_q)
            S_IF: begin
                bus.mem_re = 1'b1;
                alu_src_b  = SRCB_FOUR;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                alu_src_b = SRCB_IMM4;
                if (cls.is_j) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_JUMP;
                    state_d = S_IF;
                end else if (cls.is_ill) begin
                    ill_instr = 1'b1;
                    state_d   = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                alu_src_a = 1'b1;
                unique case (1'b1)
                    cls.is_r: begin
                        aluop   = ALUOP_FUNCT;
                        cmpflag = (funct == FN_CMP);
                        state_d = S_WB;
                    end
                    cls.is_imm: begin
                        alu_src_b = SRCB_IMM;
                        aluop     = ALUOP_ADDI;
                        state_d   = S_WB;
                    end
                    cls.is_mem: begin
                        alu_src_b = SRCB_IMM;
                        state_d   = S_MEM;
                    end
                    cls.is_br: begin
                        aluop   = ALUOP_SUB;
                        pc_src  = PC_ALUOUT;
                        pc_we   = zero;
                        state_d = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                bus.iord   = 1'b1;
                bus.mem_re = cls.is_ld;
                bus.mem_we = !cls.is_ld;
                if (bus.mem_ready)
                    state_d = cls.is_ld ? S_WB : S_IF;
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = cls.is_r;
                mem_to_reg = cls.is_ld;
                state_d    = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // A timed-out access abandons everything and restarts fetch.
        if (rst || timeout) begin
            {pc_we, pc_src, ir_we, bus.iord, bus.mem_re, bus.mem_we} = '0;
            {reg_we, reg_dst, mem_to_reg, alu_src_a} = '0;
            {alu_src_b, aluop, cmpflag, ill_instr} = '0;
            bus_err = timeout;
            state_d = S_IF;
        end

        if (timeout || state_d != state_q)
            wait_d = '0;
        else if (waiting)
            wait_d = wait_q + 8'd1;
        else
            wait_d = wait_q;
    end

`ifdef CTRL_PERF_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        unique case (state_q)
            S_ID:    retire = cls.is_j;
            S_EX:    retire = cls.is_br;
            S_MEM:   retire = !cls.is_ld && bus.mem_ready;
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
        end else begin
            perf_cycles  <= perf_cycles + 1'b1;
            perf_retired <= perf_retired + PERF_W'(retire);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven check of multicycle_ctrl outputs, plus reset-in-MEM and timeout sequences.
module tb_multicycle_ctrl;
    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       iord;
        logic       mem_re;
        logic       mem_we;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       cmpflag;
        logic       ill_instr;
        logic       bus_err;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        out_t       exp;
    } vec_t;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000, FCMP = 6'b111000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic zero = 1'b0;
    logic pc_we, ir_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic cmpflag, ill_instr, bus_err;
    logic [1:0] pc_src, alu_src_b, aluop;
`ifdef CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_retired;
`endif

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .bus        (bus),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .aluop      (aluop),
        .cmpflag    (cmpflag),
        .ill_instr  (ill_instr),
        .bus_err    (bus_err)
`ifdef CTRL_PERF_EN
        , .perf_cycles  (perf_cycles)
        , .perf_retired (perf_retired)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    out_t e0, e_ifw, e_ifr, e_id, e_idj, e_ill, e_exr, e_excmp, e_exai;
    out_t e_exm, e_bq1, e_bq0, e_mlw, e_msw, e_wbr, e_wbai, e_wblw, e_berr;

    task automatic v(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic rd, input out_t e);
        vec_t t;
        t.rst = r; t.op = o; t.fn = f; t.z = z; t.rdy = rd; t.exp = e;
        tbl.push_back(t);
    endtask

    // One clock per call: drive at negedge, compare 1 ns later.
    task automatic apply(input vec_t t, input string name);
        out_t got;
        @(negedge clk);
        rst = t.rst;
        opcode = t.op;
        funct = t.fn;
        zero = t.z;
        bus.mem_ready = t.rdy;
        #1;
        got = {pc_we, pc_src, ir_we, bus.iord, bus.mem_re, bus.mem_we,
               reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluop,
               cmpflag, ill_instr, bus_err};
        checks++;
        if (got !== t.exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, t.exp);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] o, input logic z,
                        input logic rd, input out_t e, input string name);
        vec_t t;
        t.rst = r; t.op = o; t.fn = FADD; t.z = z; t.rdy = rd; t.exp = e;
        apply(t, name);
    endtask

    initial begin
        bus.mem_ready = 1'b0;

        e0      = '0;
        e_ifw   = '{mem_re: 1'b1, alu_src_b: 2'b01, default: '0};
        e_ifr   = '{mem_re: 1'b1, alu_src_b: 2'b01, ir_we: 1'b1, pc_we: 1'b1, default: '0};
        e_id    = '{alu_src_b: 2'b11, default: '0};
        e_idj   = '{alu_src_b: 2'b11, pc_we: 1'b1, pc_src: 2'b10, default: '0};
        e_ill   = '{alu_src_b: 2'b11, ill_instr: 1'b1, default: '0};
        e_exr   = '{alu_src_a: 1'b1, aluop: 2'd2, default: '0};
        e_excmp = '{alu_src_a: 1'b1, aluop: 2'd2, cmpflag: 1'b1, default: '0};
        e_exai  = '{alu_src_a: 1'b1, alu_src_b: 2'b10, aluop: 2'd3, default: '0};
        e_exm   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
        e_bq1   = '{alu_src_a: 1'b1, aluop: 2'd1, pc_src: 2'b01, pc_we: 1'b1, default: '0};
        e_bq0   = '{alu_src_a: 1'b1, aluop: 2'd1, pc_src: 2'b01, default: '0};
        e_mlw   = '{iord: 1'b1, mem_re: 1'b1, default: '0};
        e_msw   = '{iord: 1'b1, mem_we: 1'b1, default: '0};
        e_wbr   = '{reg_we: 1'b1, reg_dst: 1'b1, default: '0};
        e_wbai  = '{reg_we: 1'b1, default: '0};
        e_wblw  = '{reg_we: 1'b1, mem_to_reg: 1'b1, default: '0};
        e_berr  = '{bus_err: 1'b1, default: '0};

        v(1, RT, FADD, 0, 1, e0);
        v(1, RT, FADD, 0, 1, e0);
        // add: 4 cycles, then IF again in cycle 5
        v(0, RT, FADD, 0, 1, e_ifr);
        v(0, RT, FADD, 0, 1, e_id);
        v(0, RT, FADD, 0, 1, e_exr);
        v(0, RT, FADD, 0, 1, e_wbr);
        v(0, RT, FADD, 0, 0, e_ifw);
        // R-type compare
        v(0, RT, FCMP, 0, 1, e_ifr);
        v(0, RT, FCMP, 0, 1, e_id);
        v(0, RT, FCMP, 0, 1, e_excmp);
        v(0, RT, FCMP, 0, 1, e_wbr);
        // addi with funct bits matching FN_CMP must not raise cmpflag
        v(0, AI, FCMP, 0, 1, e_ifr);
        v(0, AI, FCMP, 0, 1, e_id);
        v(0, AI, FCMP, 0, 1, e_exai);
        v(0, AI, FCMP, 0, 1, e_wbai);
        // lw with 3 wait states in MEM: 8 cycles
        v(0, LW, FADD, 0, 1, e_ifr);
        v(0, LW, FADD, 0, 1, e_id);
        v(0, LW, FADD, 0, 1, e_exm);
        v(0, LW, FADD, 0, 0, e_mlw);
        v(0, LW, FADD, 0, 0, e_mlw);
        v(0, LW, FADD, 0, 0, e_mlw);
        v(0, LW, FADD, 0, 1, e_mlw);
        v(0, LW, FADD, 0, 1, e_wblw);
        // sw
        v(0, SW, FADD, 0, 1, e_ifr);
        v(0, SW, FADD, 0, 1, e_id);
        v(0, SW, FADD, 0, 1, e_exm);
        v(0, SW, FADD, 0, 1, e_msw);
        // beq taken / not taken
        v(0, BQ, FADD, 1, 1, e_ifr);
        v(0, BQ, FADD, 1, 1, e_id);
        v(0, BQ, FADD, 1, 1, e_bq1);
        v(0, BQ, FADD, 0, 1, e_ifr);
        v(0, BQ, FADD, 0, 1, e_id);
        v(0, BQ, FADD, 0, 1, e_bq0);
        // j, then illegal opcode, then a normal add
        v(0, JJ, FADD, 0, 1, e_ifr);
        v(0, JJ, FADD, 0, 1, e_idj);
        v(0, BAD, FCMP, 0, 1, e_ifr);
        v(0, BAD, FCMP, 0, 1, e_ill);
        v(0, RT, FADD, 0, 1, e_ifr);
        v(0, RT, FADD, 0, 1, e_id);
        v(0, RT, FADD, 0, 1, e_exr);
        v(0, RT, FADD, 0, 1, e_wbr);

        foreach (tbl[i])
            apply(tbl[i], $sformatf("vec%0d", i));

        // reset held 3 cycles while sw is stalled in MEM
        step(0, SW, 0, 1, e_ifr, "rst_sw_if");
        step(0, SW, 0, 1, e_id, "rst_sw_id");
        step(0, SW, 0, 1, e_exm, "rst_sw_ex");
        step(0, SW, 0, 0, e_msw, "rst_sw_mem");
        step(1, SW, 0, 0, e0, "rst_drop1");
        step(1, SW, 0, 0, e0, "rst_drop2");
        step(1, SW, 0, 0, e0, "rst_drop3");
        step(0, SW, 0, 0, e_ifw, "rst_release_if");
        step(0, SW, 0, 1, e_ifr, "rst_if_done");
        step(0, SW, 0, 1, e_id, "rst_sw2_id");
        step(0, SW, 0, 1, e_exm, "rst_sw2_ex");
        step(0, SW, 0, 1, e_msw, "rst_sw2_mem");

        // timeout after 4 stalled IF cycles, then limit-cycle ready wins
        for (int k = 0; k < 4; k++)
            step(0, JJ, 0, 0, e_ifw, $sformatf("to_wait%0d", k));
        step(0, JJ, 0, 0, e_berr, "to_bus_err");
        for (int k = 0; k < 4; k++)
            step(0, JJ, 0, 0, e_ifw, $sformatf("to_rewait%0d", k));
        step(0, JJ, 0, 1, e_ifr, "to_ready_at_limit");
        step(0, JJ, 0, 1, e_idj, "to_after_j");
        step(0, RT, 0, 0, e_ifw, "to_next_if");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
